// File: rtl/seq_adder_pkg.sv
// seq_adder_pkg: shared constants for the slice-serial adder.
//   - controller state encodings (IDLE / RUN / DONE)
//   - default operand width and slice width
//   - slice-count derivation
package seq_adder_pkg;

   localparam int DEF_WIDTH  = 16;
   localparam int DEF_SLICE  = 4;
   localparam int DEF_NSLICE = DEF_WIDTH / DEF_SLICE;

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] RUN  = 2'b01;
   localparam logic [1:0] DONE = 2'b10;

   // Number of slice passes needed for a w-bit add with s-bit slices.
   function automatic int nslice(input int w, input int s);
      return w / s;
   endfunction

endpackage

// File: rtl/adder_slice_cin.sv
// full_adder: single-bit full-adder cell.
//   a, b, ci : addend bits and carry-in
//   s, co    : sum bit and carry-out
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

// adder_slice_cin: combinational SLICE-bit ripple-carry adder with an
// explicit carry-in, built as a chain of full_adder cells.
//   x, y : SLICE-bit addends
//   ci   : carry into bit 0
//   s    : SLICE-bit sum
//   co   : carry out of the top bit
module adder_slice_cin
   import seq_adder_pkg::*;
#(
   parameter int SLICE = DEF_SLICE
) (
   input  logic [SLICE-1:0] x,
   input  logic [SLICE-1:0] y,
   input  logic             ci,
   output logic [SLICE-1:0] s,
   output logic             co
);
   logic [SLICE:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < SLICE; i++) begin : g_bit
      full_adder u_fa (
         .a  (x[i]),
         .b  (y[i]),
         .ci (c[i]),
         .s  (s[i]),
         .co (c[i+1])
      );
   end

   assign co = c[SLICE];
endmodule

// File: rtl/seq_adder_ctrl.sv
// seq_adder_ctrl: WIDTH-bit adder that reuses one SLICE-bit ripple slice
// over NSLICE cycles, least-significant slice first, with the inter-slice
// carry held in a register.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   start      : request; taken only in IDLE or DONE
//   a, b, cin  : operands and carry-in, latched when start is taken
//   busy       : high while slices are being processed
//   done       : one-cycle pulse, sum/cout/ovf valid
//   sum        : result, held from done until the next accepted start
//   cout       : carry out of the MSB
//   ovf        : signed overflow of the add
module seq_adder_ctrl
   import seq_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SLICE = DEF_SLICE
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int NSLICE = nslice(WIDTH, SLICE);
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

   logic [1:0]       state;
   logic [IDX_W-1:0] idx;
   logic [WIDTH-1:0] a_r, b_r, sum_r;
   logic             carry, cout_r, ovf_r;

   logic [SLICE-1:0] sx, sy, ss;
   logic             sco;
   int               base;
   logic             accept, last;

   assign base   = int'(idx) * SLICE;
   assign sx     = a_r[base +: SLICE];
   assign sy     = b_r[base +: SLICE];
   assign accept = start && (state == IDLE || state == DONE);
   assign last   = (idx == LAST_IDX);

   adder_slice_cin #(.SLICE(SLICE)) u_slice (
      .x  (sx),
      .y  (sy),
      .ci (carry),
      .s  (ss),
      .co (sco)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         idx    <= '0;
         a_r    <= '0;
         b_r    <= '0;
         carry  <= 1'b0;
         sum_r  <= '0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else if (accept) begin
         // Clearing sum here is what makes unprocessed slices read 0.
         state  <= RUN;
         idx    <= '0;
         a_r    <= a;
         b_r    <= b;
         carry  <= cin;
         sum_r  <= '0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else if (state == RUN) begin
         sum_r[base +: SLICE] <= ss;
         carry <= sco;
         idx   <= idx + 1'b1;
         if (last) begin
            cout_r <= sco;
            // Top slice's MSB is the final sum MSB.
            ovf_r  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (ss[SLICE-1] != a_r[WIDTH-1]);
            state  <= DONE;
         end
      end else begin
         // DONE without a new start, IDLE, or an unused encoding.
         state <= IDLE;
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);
   assign sum  = sum_r;
   assign cout = cout_r;
   assign ovf  = ovf_r;
endmodule

// File: tb/tb_seq_adder_ctrl.sv
// tb_seq_adder_ctrl: directed self-checking bench for seq_adder_ctrl.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_seq_adder_ctrl;
   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] a, b;
   logic        cin;
   logic        busy, done, cout, ovf;
   logic [15:0] sum;

   int n_cmp = 0;
   int n_err = 0;

   seq_adder_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Full transaction: request on a falling edge, 4 busy cycles, done, then idle.
   task automatic run_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                         input logic ic, input logic [15:0] es, input logic ec, input logic eo);
      @(negedge clk);
      a = ia; b = ib; cin = ic; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = 16'hDEAD; b = 16'hBEEF; cin = ~ic;   // must not disturb the run
      chk({tag, ".sum_clr"}, 32'(sum), 32'h0);
      for (int k = 0; k < 4; k++) begin
         chk({tag, ".busy"}, 32'(busy), 32'h1);
         chk({tag, ".nodone"}, 32'(done), 32'h0);
         @(negedge clk);
      end
      chk({tag, ".done"}, 32'(done), 32'h1);
      chk({tag, ".busy_lo"}, 32'(busy), 32'h0);
      chk({tag, ".sum"}, 32'(sum), 32'(es));
      chk({tag, ".cout"}, 32'(cout), 32'(ec));
      chk({tag, ".ovf"}, 32'(ovf), 32'(eo));
      @(negedge clk);
      chk({tag, ".done_1cyc"}, 32'(done), 32'h0);
      chk({tag, ".sum_hold"}, 32'(sum), 32'(es));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst.busy", 32'(busy), 32'h0);
      chk("rst.done", 32'(done), 32'h0);
      chk("rst.sum",  32'(sum),  32'h0);
      chk("rst.cout", 32'(cout), 32'h0);
      chk("rst.ovf",  32'(ovf),  32'h0);
      reset = 1'b0;

      run_op("t1",  16'h1388, 16'h1770, 1'b0, 16'h2AF8, 1'b0, 1'b0);
      run_op("t2",  16'h00FF, 16'h0F00, 1'b1, 16'h1000, 1'b0, 1'b0);
      run_op("t3a", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("t3b", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);

      // Start while busy is ignored.
      @(negedge clk);
      a = 16'h0001; b = 16'h0002; cin = 1'b0; start = 1'b1;
      @(negedge clk);                    // after E0
      start = 1'b0;
      @(negedge clk);                    // after E1: slice 0 = 1+2
      chk("t4.partial", 32'(sum), 32'h0003);
      a = 16'hAAAA; b = 16'h5555; start = 1'b1;
      @(negedge clk);                    // after E2
      start = 1'b0;
      chk("t4.busy", 32'(busy), 32'h1);
      chk("t4.partial2", 32'(sum), 32'h0003);
      @(negedge clk);                    // after E3
      chk("t4.nodone", 32'(done), 32'h0);
      @(negedge clk);                    // after E4
      chk("t4.done", 32'(done), 32'h1);
      chk("t4.sum", 32'(sum), 32'h0003);
      @(negedge clk);
      chk("t4.done_once", 32'(done), 32'h0);
      chk("t4.idle", 32'(busy), 32'h0);

      // Back-to-back: new start during the done cycle.
      a = 16'd10; b = 16'd20; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("t5.done1", 32'(done), 32'h1);
      chk("t5.sum1", 32'(sum), 32'd30);
      a = 16'd100; b = 16'd200; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("t5.busy2", 32'(busy), 32'h1);
      chk("t5.done_lo", 32'(done), 32'h0);
      chk("t5.sum_clr", 32'(sum), 32'h0);
      repeat (3) @(negedge clk);
      chk("t5.still_busy", 32'(busy), 32'h1);
      @(negedge clk);
      chk("t5.done2", 32'(done), 32'h1);
      chk("t5.sum2", 32'(sum), 32'd300);

      // Asynchronous reset in the middle of a run.
      @(negedge clk);
      a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
      @(negedge clk);                    // after E0
      start = 1'b0;
      repeat (2) @(negedge clk);         // after E2: slices 0,1 done
      chk("t6.partial", 32'(sum), 32'h0045);
      #2 reset = 1'b1;
      #1;
      chk("t6.rst_busy", 32'(busy), 32'h0);
      chk("t6.rst_done", 32'(done), 32'h0);
      chk("t6.rst_sum",  32'(sum),  32'h0);
      chk("t6.rst_cout", 32'(cout), 32'h0);
      chk("t6.rst_ovf",  32'(ovf),  32'h0);
      @(negedge clk);
      reset = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("t6.no_done", 32'(done), 32'h0);
      end
      run_op("t6b", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
